// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if
//   Bundles the signals between the UART receiver, the command decoder, the
//   VGA register bank and the optional ACK/NAK transmitter path.
//   Signals:
//     rx_strobe  1  one-cycle pulse, rx_byte valid
//     rx_byte    8  received byte
//     rx_error   1  receiver error level (sticky in the receiver)
//     wr_strobe  1  one-cycle register-write pulse
//     wr_addr    8  register address, held until next write
//     wr_data    8  register data, held until next write
//     err_count  8  saturating count of rejected frames
//     ack_valid  1  ACK/NAK byte available
//     ack_byte   8  8'h06 ACK / 8'h15 NAK
//     ack_ready  1  downstream transmitter accepts ack_byte
//   Modports: master = byte source / result sink, slave = decoder.
interface uart_cmd_decoder_if;
    logic       rx_strobe;
    logic [7:0] rx_byte;
    logic       rx_error;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] err_count;
    logic       ack_valid;
    logic [7:0] ack_byte;
    logic       ack_ready;

    modport master (
        output rx_strobe, rx_byte, rx_error, ack_ready,
        input  wr_strobe, wr_addr, wr_data, err_count, ack_valid, ack_byte
    );

    modport slave (
        input  rx_strobe, rx_byte, rx_error, ack_ready,
        output wr_strobe, wr_addr, wr_data, err_count, ack_valid, ack_byte
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Assembles 4-byte frames (SYNC, ADDR, DATA, CHK) from UART receiver bytes
//   and issues a single-cycle register write for each frame whose CHK equals
//   ADDR^DATA. Bad checksums, in-frame timeouts and receiver-error rising
//   edges abort the frame and bump a saturating error counter.
//   Ports:
//     clk  1  system clock
//     rst  1  asynchronous reset, active-high
//     bus     uart_cmd_decoder_if.slave (rx bytes in, register write,
//             error count and ACK/NAK handshake out)
//   Parameters:
//     SYNC_BYTE     frame start marker
//     TIMEOUT_CLKS  idle clocks tolerated between bytes inside a frame
//   Build option:
//     UART_CMD_ACK_EN  when defined, each checksum decision produces an
//                      ACK (8'h06) or NAK (8'h15) on a valid/ready output;
//                      otherwise ack_valid/ack_byte are tied low.
module uart_cmd_decoder #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 250000
) (
    input logic               clk,
    input logic               rst,
    uart_cmd_decoder_if.slave bus
);
    localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]           ACK_BYTE = 8'h06;
    localparam logic [7:0]           NAK_BYTE = 8'h15;

    typedef enum logic [1:0] {
        S_SYNC,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [7:0]       addr_q, addr_next;
    logic [7:0]       data_q, data_next;
    logic             rx_error_q;
    logic             wr_strobe_q, wr_strobe_next;
    logic [7:0]       wr_addr_q, wr_addr_next;
    logic [7:0]       wr_data_q, wr_data_next;
    logic [7:0]       err_count_q, err_count_next;
    logic             err_bump;
    logic             err_rise;
    logic             timeout;
    logic             result_valid;
    logic             result_ok;

    assign err_rise = bus.rx_error & ~rx_error_q;
    assign timeout  = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_SYNC;
            cnt         <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rx_error_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_count_q <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            addr_q      <= addr_next;
            data_q      <= data_next;
            rx_error_q  <= bus.rx_error;
            wr_strobe_q <= wr_strobe_next;
            wr_addr_q   <= wr_addr_next;
            wr_data_q   <= wr_data_next;
            err_count_q <= err_count_next;
        end
    end

    // Inside a frame the abort priority is: receiver-error edge, then a
    // received byte, then timeout (so a byte landing on the timeout cycle
    // is still accepted).
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        addr_next      = addr_q;
        data_next      = data_q;
        wr_strobe_next = 1'b0;
        wr_addr_next   = wr_addr_q;
        wr_data_next   = wr_data_q;
        err_bump       = 1'b0;
        result_valid   = 1'b0;
        result_ok      = 1'b0;

        if (state == S_SYNC) begin
            cnt_next = '0;
            if (bus.rx_strobe && (bus.rx_byte == SYNC_BYTE)) begin
                state_next = S_ADDR;
            end
        end else if (err_rise) begin
            state_next = S_SYNC;
            cnt_next   = '0;
            err_bump   = 1'b1;
        end else if (bus.rx_strobe) begin
            cnt_next = '0;
            case (state)
                S_ADDR: begin
                    addr_next  = bus.rx_byte;
                    state_next = S_DATA;
                end
                S_DATA: begin
                    data_next  = bus.rx_byte;
                    state_next = S_CHK;
                end
                S_CHK: begin
                    state_next   = S_SYNC;
                    result_valid = 1'b1;
                    if (bus.rx_byte == (addr_q ^ data_q)) begin
                        result_ok      = 1'b1;
                        wr_strobe_next = 1'b1;
                        wr_addr_next   = addr_q;
                        wr_data_next   = data_q;
                    end else begin
                        err_bump = 1'b1;
                    end
                end
                default: state_next = S_SYNC;
            endcase
        end else if (timeout) begin
            state_next = S_SYNC;
            cnt_next   = '0;
            err_bump   = 1'b1;
        end else begin
            cnt_next = cnt + 1'b1;
        end

        err_count_next = err_count_q;
        if (err_bump && (err_count_q != 8'hFF)) begin
            err_count_next = err_count_q + 8'd1;
        end
    end

    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.err_count = err_count_q;

`ifdef UART_CMD_ACK_EN
    logic       ack_valid_q;
    logic [7:0] ack_byte_q;

    // A fresh result overwrites a still-pending one and keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_valid_q <= 1'b0;
            ack_byte_q  <= '0;
        end else if (result_valid) begin
            ack_valid_q <= 1'b1;
            ack_byte_q  <= result_ok ? ACK_BYTE : NAK_BYTE;
        end else if (ack_valid_q && bus.ack_ready) begin
            ack_valid_q <= 1'b0;
        end
    end

    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_byte  = ack_byte_q;
`else
    logic unused_ack;

    assign unused_ack    = bus.ack_ready ^ result_valid ^ result_ok
                         ^ (ACK_BYTE[0] & NAK_BYTE[0]);
    assign bus.ack_valid = 1'b0;
    assign bus.ack_byte  = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder
//   Drives directed and randomized byte streams into uart_cmd_decoder and
//   compares every output on every cycle against a frame-level reference
//   model (byte queue + cycle stamps). Honours UART_CMD_ACK_EN.
module tb_uart_cmd_decoder;
    localparam int unsigned TO = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_cmd_decoder_if bus();

    uart_cmd_decoder #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // reference model state
    logic [7:0]  fq[$];
    int unsigned cyc      = 0;
    int unsigned last_stb = 0;
    logic        err_prev = 1'b0;
    logic        exp_wr_strobe = 1'b0;
    logic [7:0]  exp_addr  = '0;
    logic [7:0]  exp_data  = '0;
    logic [7:0]  exp_err   = '0;
    logic        exp_ack_valid = 1'b0;
    logic [7:0]  exp_ack_byte  = '0;

    logic        cur_err    = 1'b0;
    int unsigned ready_mode = 0;   // 0 random, 1 force low, 2 force high

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic bump_err();
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endtask

    task automatic model_edge(input logic stb, input logic [7:0] b, input logic err,
                              input logic rdy);
        logic rise, result, ok;
        rise     = err && !err_prev;
        err_prev = err;
        result   = 1'b0;
        ok       = 1'b0;
        exp_wr_strobe = 1'b0;
        if (fq.size() != 0 && (rise || (!stb && (cyc - last_stb == TO)))) begin
            fq.delete();
            bump_err();
        end else if (stb) begin
            last_stb = cyc;
            if (fq.size() == 0) begin
                if (b == 8'hA5) fq.push_back(b);
            end else begin
                fq.push_back(b);
                if (fq.size() == 4) begin
                    result = 1'b1;
                    ok     = (fq[3] == (fq[1] ^ fq[2]));
                    if (ok) begin
                        exp_wr_strobe = 1'b1;
                        exp_addr      = fq[1];
                        exp_data      = fq[2];
                    end else begin
                        bump_err();
                    end
                    fq.delete();
                end
            end
        end
`ifdef UART_CMD_ACK_EN
        if (result) begin
            exp_ack_valid = 1'b1;
            exp_ack_byte  = ok ? 8'h06 : 8'h15;
        end else if (exp_ack_valid && rdy) begin
            exp_ack_valid = 1'b0;
        end
`else
        if (rdy && result && ok) exp_ack_valid = 1'b0;
`endif
        cyc++;
    endtask

    task automatic check_all();
        check("wr_strobe", 8'(bus.wr_strobe), 8'(exp_wr_strobe));
        check("wr_addr",   bus.wr_addr,       exp_addr);
        check("wr_data",   bus.wr_data,       exp_data);
        check("err_count", bus.err_count,     exp_err);
        check("ack_valid", 8'(bus.ack_valid), 8'(exp_ack_valid));
        check("ack_byte",  bus.ack_byte,      exp_ack_byte);
    endtask

    // one clock: drive at negedge, advance model, check at next negedge
    task automatic cycle(input logic stb, input logic [7:0] b);
        logic rdy;
        case (ready_mode)
            1:       rdy = 1'b0;
            2:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        bus.rx_strobe = stb;
        bus.rx_byte   = b;
        bus.rx_error  = cur_err;
        bus.ack_ready = rdy;
        model_edge(stb, b, cur_err, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [7:0] b, input int unsigned gap);
        for (int unsigned i = 1; i < gap; i++) cycle(1'b0, 8'($urandom));
        cycle(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(8'hA5, 1);
        send(a, 1);
        send(d, 1);
        send(c, 1);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.rx_strobe = 1'b0;
        bus.rx_error  = 1'b0;
        cur_err       = 1'b0;
        #2;
        check("rst_wr_strobe", 8'(bus.wr_strobe), 8'h00);
        check("rst_wr_addr",   bus.wr_addr,       8'h00);
        check("rst_wr_data",   bus.wr_data,       8'h00);
        check("rst_err_count", bus.err_count,     8'h00);
        check("rst_ack_valid", 8'(bus.ack_valid), 8'h00);
        check("rst_ack_byte",  bus.ack_byte,      8'h00);
        fq.delete();
        err_prev      = 1'b0;
        exp_wr_strobe = 1'b0;
        exp_addr      = '0;
        exp_data      = '0;
        exp_err       = '0;
        exp_ack_valid = 1'b0;
        exp_ack_byte  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] a, d, c;
        int unsigned r;
        bus.rx_strobe = 1'b0;
        bus.rx_byte   = '0;
        bus.rx_error  = 1'b0;
        bus.ack_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // basic frame, write one clock after CHK strobe
        send_frame(8'h10, 8'h3C, 8'h2C);
        check("t1_strobe", 8'(bus.wr_strobe), 8'h01);
        check("t1_addr",   bus.wr_addr,       8'h10);
        check("t1_data",   bus.wr_data,       8'h3C);

        // leading junk ignored without counting
        send(8'h00, 1);
        send(8'hFF, 1);
        send_frame(8'h01, 8'h02, 8'h03);
        check("t2_addr", bus.wr_addr,   8'h01);
        check("t2_err",  bus.err_count, 8'h00);

        // bad checksum
        send_frame(8'h01, 8'h02, 8'h04);
        check("t3_err", bus.err_count, 8'h01);
`ifdef UART_CMD_ACK_EN
        check("t3_nak", bus.ack_byte, 8'h15);
`endif

        // stall past the timeout, trailing bytes discarded
        send(8'hA5, 1);
        send(8'h01, 1);
        send(8'h02, TO + 1);
        send(8'h03, 1);
        check("t4_err", bus.err_count, 8'h02);
        // byte landing exactly on the timeout cycle is accepted
        send(8'hA5, 1);
        send(8'h05, 1);
        send(8'h06, TO);
        send(8'h03, 1);
        check("t4_edge_strobe", 8'(bus.wr_strobe), 8'h01);
        check("t4_edge_err",    bus.err_count,     8'h02);

        // receiver error edge mid-frame
        send(8'hA5, 1);
        send(8'h07, 1);
        cur_err = 1'b1;
        cycle(1'b0, 8'h00);
        cur_err = 1'b0;
        cycle(1'b0, 8'h00);
        check("t5_err", bus.err_count, 8'h03);
        send_frame(8'h07, 8'h08, 8'h0F);
        check("t5_addr", bus.wr_addr, 8'h07);
        check("t5_data", bus.wr_data, 8'h08);

        // ACK held while not ready, latest result wins, drops after ready
        ready_mode = 1;
        send_frame(8'h11, 8'h22, 8'h33);
        send_frame(8'h44, 8'h55, 8'h11);
`ifdef UART_CMD_ACK_EN
        check("t6_valid_held", 8'(bus.ack_valid), 8'h01);
        check("t6_ack_byte",   bus.ack_byte,      8'h06);
`endif
        ready_mode = 2;
        cycle(1'b0, 8'h00);
        ready_mode = 1;
        cycle(1'b0, 8'h00);
        check("t6_valid_drop", 8'(bus.ack_valid), 8'h00);
        ready_mode = 0;

        // randomized frames with varied gaps, checksums and error pulses
        for (int unsigned f = 0; f < 400; f++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            c = ($urandom_range(0, 3) != 0) ? (a ^ d) : 8'($urandom);
            for (int unsigned k = 0; k < 4; k++) begin
                logic [7:0] b;
                case (k)
                    0:       b = ($urandom_range(0, 9) != 0) ? 8'hA5 : 8'($urandom);
                    1:       b = a;
                    2:       b = d;
                    default: b = c;
                endcase
                if ($urandom_range(0, 29) == 0) cur_err = ~cur_err;
                r = $urandom_range(0, 19);
                if (r == 0)      send(b, TO);
                else if (r == 1) send(b, TO + 1);
                else             send(b, $urandom_range(1, 3));
            end
        end
        cur_err = 1'b0;
        cycle(1'b0, 8'h00);

        // error counter saturates
        for (int unsigned f = 0; f < 300; f++) begin
            send_frame(8'(f), 8'h5A, 8'(f) ^ 8'h5B);
        end
        check("t5_saturate", bus.err_count, 8'hFF);
        send_frame(8'h01, 8'h01, 8'h01);
        check("t5_no_wrap", bus.err_count, 8'hFF);

        // reset mid-frame loses the partial frame
        send(8'hA5, 1);
        send(8'h09, 1);
        @(negedge clk);
        do_reset();
        send(8'h0A, 1);
        send(8'h0B, 1);
        send_frame(8'h20, 8'h30, 8'h10);
        check("t6_post_reset_addr", bus.wr_addr,   8'h20);
        check("t6_post_reset_err",  bus.err_count, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
